g2_run_ctrl: RTL and testbench
==============================

G2_RUN_CTRL -- requirements
Module: g2_run_ctrl

Interface
REQ-001 Parameters SHALL be:
  - iSIZE, default 31, data MSB.
  - g2MemAddrBit, default 9, histogram address MSB; dump length = 2^(g2MemAddrBit+1) words.
  - cntBit, default 31, event-count MSB.
  - drainCycles, default 64, pipeline drain time in clk cycles.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock.
  - RST  in  1  asynchronous active-low reset.
REQ-003 Host ports:
  - start  in  1  run request, sampled in IDLE.
  - runLen  in  cntBit+1  number of accepted a1 events per run.
  - busy  out  1  high outside IDLE.
  - done  out  1  one-cycle pulse at end of dump.
  - hA1  in  iSIZE+1  host a1 data.
  - hA1V  in  1  host a1 valid.
  - hA1R  out  1  host a1 ready.
  - hA2  in  iSIZE+1  host a2 data.
  - hA2V  in  1  host a2 valid.
  - hA2R  out  1  host a2 ready.
  - oDat  out  iSIZE+1  dump data.
  - oV  out  1  dump valid.
  - oR  in  1  dump ready.
REQ-004 Calculator-side ports:
  - a1  out  iSIZE+1  a1 data.
  - a1V  out  1  a1 valid.
  - a1R  in  1  a1 ready.
  - a2  out  iSIZE+1  a2 data.
  - a2V  out  1  a2 valid.
  - a2R  in  1  a2 ready.
  - g2Rst  out  1  calculator readout trigger (falling edge starts dump).
  - g2Dat  in  iSIZE+1  dump data.
  - g2V  in  1  dump valid.
  - g2R  out  1  dump advance.

Function
REQ-005 FSM states SHALL be IDLE, ACQ, DRAIN, TRIG, DUMP, DONE.
REQ-006 IDLE: all valids/readies low, g2Rst=1; start=1 latches runLen, clears counters, goes to ACQ next cycle.
REQ-007 start=1 with runLen=0 SHALL skip ACQ and go directly to DRAIN.
REQ-008 ACQ: a1/a2 SHALL be combinational pass-throughs (a1=hA1, a1V=hA1V, hA1R=a1R; same for a2).
REQ-009 ACQ: evtCnt SHALL increment on each a1V&&a1R beat; on the beat making evtCnt==runLen, hA1R goes low from the next cycle and the FSM goes to DRAIN.
REQ-010 ACQ: a2 beats SHALL be counted into a2Cnt (saturating at all-ones), not limited.
REQ-011 DRAIN: all host readies and calculator valids low; a down-counter loaded with drainCycles SHALL expire, then go to TRIG.
REQ-012 TRIG: g2Rst driven 0 for exactly one cycle, then 1 again, then DUMP.
REQ-013 DUMP: oDat=g2Dat, oV=g2V, g2R=oR&&g2V.
REQ-014 DUMP: dumpCnt (g2MemAddrBit+1 bits wide plus carry) SHALL count oV&&oR beats; after 2^(g2MemAddrBit+1) beats go to DONE.
REQ-015 DONE: done=1 for one cycle, then IDLE.
REQ-016 start SHALL be ignored outside IDLE.
REQ-017 busy=1 in every state except IDLE.
REQ-018 Latency: start to first possible a1V pass-through = 1 cycle; last a1 beat to g2Rst low = drainCycles+2 cycles.
REQ-019 Counters SHALL wrap only where stated; evtCnt compares against the latched runLen, so runLen changes mid-run have no effect.

Reset
REQ-020 RST=0 SHALL asynchronously force:
  - state IDLE; all counters 0.
  - g2Rst=1, busy=0, done=0.
  - all valids and readies 0.
REQ-021 Reset mid-run SHALL abort without issuing a g2Rst falling edge; deassertion is synchronised to clk (two-flop release).

Structure
REQ-022 State enum and the dump-length constant SHALL live in the shared package g2_pkg.
REQ-023 One sub-module, g2_beat_counter (loadable up/down counter with terminal flag), SHALL be instanced for evtCnt, the drain timer and dumpCnt.

Verification
REQ-024 runLen=4, hA1V held 1, a1R=1 -> exactly 4 a1 beats; hA1R low after the 4th; g2Rst low one cycle at drainCycles+2 after the 4th beat.
REQ-025 a1R toggling 1/0 during ACQ, runLen=3 -> evtCnt counts only handshaken beats; DRAIN entered after the 3rd.
REQ-026 DUMP with oR=1 constantly -> 1024 beats, done pulse on the cycle after the 1024th beat, then IDLE.
REQ-027 DUMP with oR stalled for 5 cycles mid-dump -> g2R=0 during the stall; no beat lost; total beats still 1024.
REQ-028 RST asserted in DUMP -> immediate IDLE, g2Rst=1, oV=0; a new start works normally.
REQ-029 start with runLen=0 -> no a1 beats; DRAIN, TRIG and DUMP proceed normally.

Source files
------------

// File: rtl/g2_pkg.sv
// Shared types and constants for the g2 run controller.
package g2_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACQ   = 3'd1,
        DRAIN = 3'd2,
        TRIG  = 3'd3,
        DUMP  = 3'd4,
        DONE  = 3'd5
    } g2_state_t;

    function automatic int g2_dump_len(input int addr_msb);
        return 1 << (addr_msb + 1);
    endfunction

    localparam int G2_DUMP_LEN = g2_dump_len(9);

endpackage

// File: rtl/g2_beat_counter.sv
// Loadable up/down counter with a terminal-count compare against term.
module g2_beat_counter #(
    parameter int W = 8
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= up ? cnt + W'(1) : cnt - W'(1);
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/g2_run_ctrl.sv
// Run controller: gates host a1/a2 streams into the calculator for one run,
// waits for the pipeline to drain, triggers readout and forwards the dump.
//
// state | meaning
// IDLE  | waiting for start, calculator held in readout-reset
// ACQ   | a1/a2 pass-through until runLen a1 beats accepted
// DRAIN | streams blocked, drain timer running
// TRIG  | g2Rst low for one cycle
// DUMP  | forwarding histogram words to host
// DONE  | done pulse, back to IDLE
module g2_run_ctrl
    import g2_pkg::*;
#(
    parameter int iSIZE        = 31,
    parameter int g2MemAddrBit = 9,
    parameter int cntBit       = 31,
    parameter int drainCycles  = 64
)(
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [cntBit:0]   runLen,
    output logic              busy,
    output logic              done,
    input  logic [iSIZE:0]    hA1,
    input  logic              hA1V,
    output logic              hA1R,
    input  logic [iSIZE:0]    hA2,
    input  logic              hA2V,
    output logic              hA2R,
    output logic [iSIZE:0]    oDat,
    output logic              oV,
    input  logic              oR,
    output logic [iSIZE:0]    a1,
    output logic              a1V,
    input  logic              a1R,
    output logic [iSIZE:0]    a2,
    output logic              a2V,
    input  logic              a2R,
    output logic              g2Rst,
    input  logic [iSIZE:0]    g2Dat,
    input  logic              g2V,
    output logic              g2R
);

    localparam int DUMP_LEN = g2_dump_len(g2MemAddrBit);
    localparam int DUMP_W   = g2MemAddrBit + 2;
    localparam int DRAIN_W  = $clog2(drainCycles + 2);
    localparam int CNT_W    = cntBit + 1;

    g2_state_t          state;
    logic [1:0]         rst_sync;
    logic               rst_n;
    logic [cntBit:0]    run_len_q;
    logic [cntBit:0]    a2_cnt;
    logic [cntBit:0]    evt_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DUMP_W-1:0]  dump_cnt;
    logic               evt_tc, drain_tc, dump_tc;
    logic               in_acq, in_dump;
    logic               a1_beat, a2_beat, dump_beat;
    logic               unused_cnts;

    // Assert immediately, release two clocks after RST rises.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign in_acq  = (state == ACQ);
    assign in_dump = (state == DUMP);

    assign a1   = hA1;
    assign a1V  = in_acq && hA1V;
    assign hA1R = in_acq && a1R;
    assign a2   = hA2;
    assign a2V  = in_acq && hA2V;
    assign hA2R = in_acq && a2R;
    assign oDat = g2Dat;
    assign oV   = in_dump && g2V;
    assign g2R  = in_dump && oR && g2V;

    assign a1_beat   = a1V && a1R;
    assign a2_beat   = a2V && a2R;
    assign dump_beat = oV && oR;

    g2_beat_counter #(.W(CNT_W)) u_evt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == IDLE),
        .load_val ('0),
        .en       (a1_beat),
        .up       (1'b1),
        .term     (run_len_q - 1'b1),
        .cnt      (evt_cnt),
        .tc       (evt_tc)
    );

    // Reloaded every cycle outside DRAIN so it holds drainCycles on entry.
    g2_beat_counter #(.W(DRAIN_W)) u_drain (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state != DRAIN),
        .load_val (DRAIN_W'(drainCycles)),
        .en       ((state == DRAIN) && !drain_tc),
        .up       (1'b0),
        .term     ('0),
        .cnt      (drain_cnt),
        .tc       (drain_tc)
    );

    g2_beat_counter #(.W(DUMP_W)) u_dump (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (!in_dump),
        .load_val ('0),
        .en       (dump_beat),
        .up       (1'b1),
        .term     (DUMP_W'(DUMP_LEN - 1)),
        .cnt      (dump_cnt),
        .tc       (dump_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            g2Rst     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            run_len_q <= '0;
            a2_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    g2Rst <= 1'b1;
                    if (start) begin
                        run_len_q <= runLen;
                        a2_cnt    <= '0;
                        busy      <= 1'b1;
                        state     <= (runLen == '0) ? DRAIN : ACQ;
                    end
                end
                ACQ: begin
                    if (a2_beat && (a2_cnt != '1)) a2_cnt <= a2_cnt + 1'b1;
                    if (a1_beat && evt_tc) state <= DRAIN;
                end
                DRAIN: begin
                    if (drain_tc) begin
                        g2Rst <= 1'b0;
                        state <= TRIG;
                    end
                end
                TRIG: begin
                    g2Rst <= 1'b1;
                    state <= DUMP;
                end
                DUMP: begin
                    if (dump_beat && dump_tc) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    g2Rst <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Counter values are kept for debug visibility only.
    assign unused_cnts = ^{evt_cnt, drain_cnt, dump_cnt, a2_cnt};

endmodule

// File: tb/tb_g2_run_ctrl.sv
// Randomized bench for g2_run_ctrl against a cycle-timeline reference model.
module tb_g2_run_ctrl;

    localparam int ISZ  = 31;
    localparam int AB   = 9;
    localparam int CB   = 31;
    localparam int DC   = 64;
    localparam int DLEN = 2 ** (AB + 1);

    logic            clk;
    logic            RST;
    logic            start;
    logic [CB:0]     runLen;
    logic            busy, done;
    logic [ISZ:0]    hA1, hA2, oDat, a1, a2, g2Dat;
    logic            hA1V, hA1R, hA2V, hA2R, oV, oR;
    logic            a1V, a1R, a2V, a2R, g2Rst, g2V, g2R;

    int checks = 0;
    int errors = 0;
    int c = 0;

    g2_run_ctrl #(
        .iSIZE(ISZ), .g2MemAddrBit(AB), .cntBit(CB), .drainCycles(DC)
    ) dut (
        .clk(clk), .RST(RST), .start(start), .runLen(runLen),
        .busy(busy), .done(done),
        .hA1(hA1), .hA1V(hA1V), .hA1R(hA1R),
        .hA2(hA2), .hA2V(hA2V), .hA2R(hA2R),
        .oDat(oDat), .oV(oV), .oR(oR),
        .a1(a1), .a1V(a1V), .a1R(a1R),
        .a2(a2), .a2V(a2V), .a2R(a2R),
        .g2Rst(g2Rst), .g2Dat(g2Dat), .g2V(g2V), .g2R(g2R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, c);
        end
    endtask

    // mode 0: everything always ready/valid; 1: a1R toggles; 2: random handshakes
    task automatic run(input int rl, input int mode, input int abort_at);
        int  s, trig, done_c, beats, dbeats, obs_a1, obs_d, low_w, stall;
        longint a2e;
        bit  acq, dmp, bsy, fin, stalled;
        s = c; trig = -1; done_c = -1; beats = 0; dbeats = 0;
        obs_a1 = 0; obs_d = 0; low_w = 0; stall = 0; a2e = 0;
        acq = 0; dmp = 0; bsy = 0; fin = 0; stalled = 0;
        for (int k = 0; k < 6000 && !fin; k++) begin
            @(posedge clk);
            #1;
            start  = (c == s) ? 1'b1 : (bsy ? ($urandom_range(0, 9) == 0) : 1'b0);
            runLen = (c == s) ? CB'(rl) : CB'($urandom_range(0, 15));
            hA1    = $urandom;
            hA2    = $urandom;
            g2Dat  = $urandom;
            hA1V   = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            a1R    = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : ($urandom_range(0, 2) != 0);
            hA2V   = $urandom_range(0, 1);
            a2R    = $urandom_range(0, 1);
            g2V    = (mode == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
            if (mode != 0 && dmp && dbeats >= 300 && !stalled) begin
                stall = 5;
                stalled = 1;
            end
            if (stall > 0) begin
                oR = 1'b0;
                stall--;
            end else begin
                oR = (mode == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
            end
            if (abort_at >= 0 && dmp && dbeats == abort_at) begin
                RST = 1'b0;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_g2Rst", g2Rst, 1);
                chk("abort_oV", oV, 0);
                chk("abort_g2R", g2R, 0);
                chk("abort_done", done, 0);
                repeat (3) @(posedge clk);
                #1 RST = 1'b1;
                start = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                chk("post_abort_g2Rst", g2Rst, 1);
                chk("post_abort_busy", busy, 0);
                return;
            end
            @(negedge clk);
            chk("a1V", a1V, acq && hA1V);
            chk("hA1R", hA1R, acq && a1R);
            chk("a2V", a2V, acq && hA2V);
            chk("hA2R", hA2R, acq && a2R);
            if (acq && hA1V) chk("a1", a1, hA1);
            chk("g2Rst", g2Rst, c != trig);
            chk("busy", busy, bsy);
            chk("done", done, c == done_c);
            chk("oV", oV, dmp && g2V);
            chk("g2R", g2R, dmp && oR && g2V);
            if (dmp && g2V) chk("oDat", oDat, g2Dat);
            if (a1V && a1R) obs_a1++;
            if (oV && oR) obs_d++;
            if (!g2Rst) low_w++;
            // advance the reference timeline to the next cycle
            if (acq && hA2V && a2R && a2e < 64'hFFFF_FFFF) a2e++;
            if (c == s) begin
                bsy = 1;
                if (rl == 0) trig = c + DC + 2;
                else acq = 1;
            end else if (acq && hA1V && a1R) begin
                beats++;
                if (beats == rl) begin
                    acq = 0;
                    trig = c + DC + 2;
                end
            end
            if (dmp && g2V && oR) begin
                dbeats++;
                if (dbeats == DLEN) begin
                    dmp = 0;
                    done_c = c + 1;
                end
            end
            if (c == trig) dmp = 1;
            if (c == done_c) fin = 1;
            c++;
        end
        if (!fin) begin
            chk("run_timeout", 0, 1);
        end else begin
            chk("a1_beats", obs_a1, rl);
            chk("dump_beats", obs_d, DLEN);
            chk("g2Rst_low_cycles", low_w, 1);
            chk("a2_cnt", dut.a2_cnt, a2e);
        end
    endtask

    initial begin
        RST = 1'b1; start = 0; runLen = '0;
        hA1 = '0; hA1V = 0; hA2 = '0; hA2V = 0; oR = 0;
        a1R = 0; a2R = 0; g2Dat = '0; g2V = 0;
        #2 RST = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_g2Rst", g2Rst, 1);
        chk("rst_done", done, 0);
        chk("rst_oV", oV, 0);
        chk("rst_hA1R", hA1R, 0);
        chk("rst_g2R", g2R, 0);
        RST = 1'b1;
        repeat (3) @(posedge clk);

        run(4, 0, -1);
        run(3, 1, -1);
        run(0, 2, -1);
        run($urandom_range(1, 8), 2, -1);
        run(5, 2, 100);
        run($urandom_range(1, 8), 2, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
